// File: rtl/region_reader.sv
// Rectangular read-back engine for the 160x120x3 frame memory.
// Walks a 1..8 x 1..8 region row-major and streams (colour, x, y).
module region_reader #(
  parameter int W_MAX = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [7:0]               x0,
  input  logic [6:0]               y0,
  input  logic [$clog2(W_MAX)-1:0] w_m1,
  input  logic [$clog2(W_MAX)-1:0] h_m1,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd,
  output logic [14:0]              mem_addr,
  input  logic [2:0]               mem_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_colour,
  output logic [7:0]               out_x,
  output logic [6:0]               out_y,
  output logic                     out_last
);

  localparam int CW = $clog2(W_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_PRES,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    x0_q, x0_d;
  logic [6:0]    y0_q, y0_d;
  logic [CW-1:0] wm1_q, wm1_d;
  logic [CW-1:0] hm1_q, hm1_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic [2:0]    col_q, col_d;

  logic [8:0]  sx;
  logic [7:0]  sy;
  logic        onscr;
  logic        at_last;
  logic [14:0] addr;

  assign sx      = {1'b0, x0_q} + 9'(cx_q);
  assign sy      = {1'b0, y0_q} + 8'(cy_q);
  assign onscr   = (sx < 9'd160) && (sy < 8'd120);
  assign at_last = (cx_q == wm1_q) && (cy_q == hm1_q);
  // y*160 as y*128 + y*32
  assign addr    = (15'(sy) << 7) + (15'(sy) << 5) + 15'(sx);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      wm1_q   <= wm1_d;
      hm1_q   <= hm1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          wm1_d   = w_m1;
          hm1_d   = h_m1;
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (onscr) begin
          state_d = S_CAPT;
        end else begin
          col_d   = '0;
          state_d = S_PRES;
        end
      end
      S_CAPT: begin
        col_d   = mem_q;
        state_d = S_PRES;
      end
      S_PRES: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (cx_q == wm1_q) begin
              cx_d = '0;
              cy_d = cy_q + CW'(1);
            end else begin
              cx_d = cx_q + CW'(1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign mem_rd     = (state_q == S_ISSUE) && onscr;
  assign mem_addr   = mem_rd ? addr : 15'd0;
  assign out_valid  = (state_q == S_PRES);
  assign out_last   = out_valid && at_last;
  assign out_colour = col_q;
  assign out_x      = sx[7:0];
  assign out_y      = sy[6:0];

endmodule

// File: tb/tb_region_reader.sv
// Directed bench for region_reader with a 1-cycle frame memory model.
// Pattern memory: colour = (x+y)&7, pixel (10,5) overridden to 5.
module tb_region_reader;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [2:0]  w_m1;
  logic [2:0]  h_m1;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [2:0]  mem_q;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_colour;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic        out_last;

  logic [2:0] mem [0:19199];

  int n_cmp;
  int n_bad;

  int npix, nrd, nb2b, ndone, done_k;
  int gx [64];
  int gy [64];
  int gc [64];
  int gl [64];

  region_reader #(.W_MAX(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w_m1       (w_m1),
    .h_m1       (h_m1),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_colour (out_colour),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_q <= mem[mem_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_region(
    input logic [7:0] ax,
    input logic [6:0] ay,
    input logic [2:0] aw,
    input logic [2:0] ah,
    input int         spix,
    input int         sn,
    input int         poke
  );
    int k;
    int scnt;
    logic [18:0] snap;
    logic prev_rd;
    npix = 0; nrd = 0; nb2b = 0; ndone = 0; done_k = 0;
    scnt = 0; prev_rd = 1'b0; snap = '0;
    @(negedge clock);
    x0 = ax; y0 = ay; w_m1 = aw; h_m1 = ah;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 1;
    while (1) begin
      if (k > 3000) begin
        chk("timeout", k, 0);
        break;
      end
      if (mem_rd) nrd++;
      if (mem_rd && prev_rd) nb2b++;
      prev_rd = mem_rd;
      start = (k == poke);
      if (k == poke) begin
        x0 = 8'd50;
        y0 = 7'd50;
      end
      if (scnt > 0 && scnt < sn) begin
        out_ready = 1'b0;
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold",
            int'({out_colour, out_x, out_y, out_last}), int'(snap));
        chk("stall_rd", int'(mem_rd), 0);
        scnt++;
      end else if (scnt == 0 && sn > 0 && out_valid && npix == spix) begin
        out_ready = 1'b0;
        snap = {out_colour, out_x, out_y, out_last};
        scnt = 1;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && npix < 64) begin
        gx[npix] = int'(out_x);
        gy[npix] = int'(out_y);
        gc[npix] = int'(out_colour);
        gl[npix] = int'(out_last);
        npix++;
      end
      if (done) begin
        ndone++;
        done_k = k;
        @(posedge clock); #1;
        chk("busy_fall", int'(busy), 0);
        chk("done_pulse", int'(done), 0);
        break;
      end
      @(posedge clock); #1;
      k++;
    end
    start = 1'b0;
  endtask

  initial begin
    int xs [6];
    int ys [6];
    int cs [6];
    int t;
    xs = '{0, 1, 2, 0, 1, 2};
    ys = '{0, 0, 0, 1, 1, 1};
    cs = '{0, 1, 2, 1, 2, 3};
    n_cmp = 0;
    n_bad = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        mem[y*160 + x] = 3'((x + y) & 7);
    mem[810] = 3'b101;
    resetn = 1'b0; start = 1'b0; out_ready = 1'b1;
    x0 = '0; y0 = '0; w_m1 = '0; h_m1 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd", int'(mem_rd), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_colour", int'(out_colour), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    @(negedge clock);
    resetn = 1'b1;

    // single pixel at (10,5)
    @(negedge clock);
    x0 = 8'd10; y0 = 7'd5; w_m1 = 3'd0; h_m1 = 3'd0;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("t1_busy", int'(busy), 1);
    chk("t1_rd", int'(mem_rd), 1);
    chk("t1_addr", int'(mem_addr), 810);
    chk("t1_valid_e1", int'(out_valid), 0);
    @(posedge clock); #1;
    chk("t1_valid_e1b", int'(out_valid), 0);
    chk("t1_rd_e1", int'(mem_rd), 0);
    @(posedge clock); #1;
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_colour", int'(out_colour), 5);
    chk("t1_x", int'(out_x), 10);
    chk("t1_y", int'(out_y), 5);
    chk("t1_last", int'(out_last), 1);
    @(posedge clock); #1;
    chk("t1_done", int'(done), 1);
    chk("t1_done_busy", int'(busy), 1);
    chk("t1_valid_off", int'(out_valid), 0);
    @(posedge clock); #1;
    chk("t1_idle", int'(busy), 0);
    chk("t1_done_off", int'(done), 0);

    // raster, then backpressure, then start-while-busy
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 0) run_region(8'd0, 7'd0, 3'd2, 3'd1, -1, 0, -1);
      else if (pass == 1) run_region(8'd0, 7'd0, 3'd2, 3'd1, 1, 5, -1);
      else run_region(8'd0, 7'd0, 3'd2, 3'd1, -1, 0, 4);
      chk("ras_npix", npix, 6);
      chk("ras_nrd", nrd, 6);
      chk("ras_done", ndone, 1);
      for (int i = 0; i < 6; i++) begin
        chk("ras_x", gx[i], xs[i]);
        chk("ras_y", gy[i], ys[i]);
        chk("ras_c", gc[i], cs[i]);
        chk("ras_last", gl[i], (i == 5) ? 1 : 0);
      end
    end
    chk("ras_b2b", nb2b, 0);

    // right/bottom clipping
    run_region(8'd158, 7'd118, 3'd3, 3'd3, -1, 0, -1);
    chk("clip_npix", npix, 16);
    chk("clip_nrd", nrd, 4);
    for (int i = 0; i < 16; i++) begin
      int ex, ey, ec;
      ex = 158 + (i % 4);
      ey = 118 + (i / 4);
      ec = (ex < 160 && ey < 120) ? ((ex + ey) & 7) : 0;
      chk("clip_x", gx[i], ex);
      chk("clip_y", gy[i], ey);
      chk("clip_c", gc[i], ec);
      chk("clip_last", gl[i], (i == 15) ? 1 : 0);
    end

    // 8x8 on-screen: last handshake at E0+192, done observed after it
    run_region(8'd0, 7'd0, 3'd7, 3'd7, -1, 0, -1);
    chk("big_npix", npix, 64);
    chk("big_nrd", nrd, 64);
    chk("big_done_k", done_k, 193);
    chk("big_b2b", nb2b, 0);
    chk("big_c63", gc[63], 6);

    // reset abort during a stall
    @(negedge clock);
    x0 = 8'd20; y0 = 7'd20; w_m1 = 3'd3; h_m1 = 3'd3;
    start = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    chk("abort_valid", int'(out_valid), 1);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_valid0", int'(out_valid), 0);
    chk("abort_rd", int'(mem_rd), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_colour", int'(out_colour), 0);
    chk("abort_x", int'(out_x), 0);
    chk("abort_y", int'(out_y), 0);
    chk("abort_last", int'(out_last), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("abort_nodone", int'(done), 0);
    end
    @(negedge clock);
    resetn = 1'b1;
    out_ready = 1'b1;

    run_region(8'd3, 7'd4, 3'd1, 3'd0, -1, 0, -1);
    chk("fresh_npix", npix, 2);
    chk("fresh_x0", gx[0], 3);
    chk("fresh_y0", gy[0], 4);
    chk("fresh_c0", gc[0], 7);
    chk("fresh_x1", gx[1], 4);
    chk("fresh_c1", gc[1], 0);
    chk("fresh_last", gl[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
